icache: RTL and testbench

ICACHE -- requirements
Module: icache

---
 rtl/cpu_types_pkg.sv | 31 +++
 rtl/icache.sv | 124 ++++++++++++
 tb/tb_icache.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache frame layout and sizing.
//   word_t          32-bit machine word
//   icache_frame_t  one direct-mapped frame {valid, tag, data}
//   icache_state_t  fill controller states
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  // Index width for a frame count (frame counts are powers of two).
  function automatic int unsigned icache_idx_w(input int unsigned nsets);
    return $clog2(nsets);
  endfunction

  localparam int unsigned ICACHE_NSETS = 16;
  localparam int unsigned ICACHE_IDX_W = icache_idx_w(ICACHE_NSETS);
  // Tag field sized for the smallest legal cache (2 frames); narrower tags zero-extend.
  localparam int unsigned ICACHE_TAG_W = WORD_W - 2 - 1;

  typedef struct packed {
    logic                    valid;
    logic [ICACHE_TAG_W-1:0] tag;
    word_t                   data;
  } icache_frame_t;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache.
//   CLK, nRST            clock, async active-low reset
//   imemREN, imemaddr    fetch request / byte address from fetch stage
//   flush                invalidate every frame (also abandons a fill)
//   ihit, imemload       combinational hit flag and instruction word
//   iREN, iaddr          read request/address to memory controller (FILL only)
//   iwait, iload         memory busy flag and read data
//   hitcnt, misscnt      wrapping performance counters
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = ICACHE_NSETS
) (
  input  logic  CLK,
  input  logic  nRST,
  input  logic  imemREN,
  input  word_t imemaddr,
  input  logic  flush,
  output logic  ihit,
  output word_t imemload,
  output logic  iREN,
  output word_t iaddr,
  input  logic  iwait,
  input  word_t iload,
  output word_t hitcnt,
  output word_t misscnt
);

  localparam int unsigned IDX_W = icache_idx_w(NSETS);
  localparam int unsigned TAG_W = WORD_W - 2 - IDX_W;

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  word_t         hitcnt_q, hitcnt_d;
  word_t         misscnt_q, misscnt_d;
  icache_frame_t frames_q [NSETS];

  logic [IDX_W-1:0]        req_idx, fill_idx;
  logic [ICACHE_TAG_W-1:0] req_tag, fill_tag;
  icache_frame_t           req_frame;
  logic                    lookup_hit;
  logic                    frame_we;
  logic [1:0]              unused_byte_sel;

  // Address split for the live lookup and for the latched miss.
  assign req_idx         = imemaddr[2 +: IDX_W];
  assign req_tag         = ICACHE_TAG_W'(imemaddr[WORD_W-1 -: TAG_W]);
  assign fill_idx        = miss_addr_q[2 +: IDX_W];
  assign fill_tag        = ICACHE_TAG_W'(miss_addr_q[WORD_W-1 -: TAG_W]);
  assign unused_byte_sel = imemaddr[1:0];

  assign req_frame  = frames_q[req_idx];
  assign lookup_hit = req_frame.valid && (req_frame.tag == req_tag);

  assign hitcnt  = hitcnt_q;
  assign misscnt = misscnt_q;

  // Next-state, counter and memory-port decode.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    hitcnt_d    = hitcnt_q;
    misscnt_d   = misscnt_q;
    ihit        = 1'b0;
    imemload    = '0;
    iREN        = 1'b0;
    iaddr       = '0;
    frame_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (imemREN && !flush) begin
          if (lookup_hit) begin
            ihit     = 1'b1;
            imemload = req_frame.data;
            hitcnt_d = hitcnt_q + 32'd1;
          end else begin
            miss_addr_d = imemaddr;
            misscnt_d   = misscnt_q + 32'd1;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        iREN  = 1'b1;
        iaddr = miss_addr_q;
        // flush outranks a completing read: the fill is dropped unwritten.
        if (flush) begin
          state_d = IDLE;
        end else if (!iwait) begin
          frame_we = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Controller state and counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      hitcnt_q    <= '0;
      misscnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      hitcnt_q    <= hitcnt_d;
      misscnt_q   <= misscnt_d;
    end
  end

  // Frame storage: only valid bits are reset; tag/data are gated by valid.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < int'(NSETS); i++) frames_q[i].valid <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < int'(NSETS); i++) frames_q[i].valid <= 1'b0;
    end else if (frame_we) begin
      frames_q[fill_idx] <= '{valid: 1'b1, tag: fill_tag, data: iload};
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (NSETS = 16).
module tb_icache;
  import cpu_types_pkg::*;

  logic  CLK;
  logic  nRST;
  logic  imemREN;
  word_t imemaddr;
  logic  flush;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  word_t hitcnt;
  word_t misscnt;

  int n_vec  = 0;
  int n_miss = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  icache #(.NSETS(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .flush    (flush),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload),
    .hitcnt   (hitcnt),
    .misscnt  (misscnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_hitcnt"}, hitcnt, 32'(exp_hit));
    check_eq({tag, "_misscnt"}, misscnt, 32'(exp_miss));
  endtask

  // Miss on addr, hold iwait for `waits` FILL cycles, then return data and see the hit.
  task automatic fill(input logic [31:0] addr, input logic [31:0] data, input int waits);
    imemREN = 1'b1; imemaddr = addr; iwait = 1'b1;
    #1;
    check_eq("fill_lookup_ihit", 32'(ihit), 32'd0);
    check_eq("fill_lookup_iren", 32'(iREN), 32'd0);
    tick(); exp_miss++;
    for (int i = 0; i < waits; i++) begin
      #1;
      check_eq("fill_wait_iren", 32'(iREN), 32'd1);
      check_eq("fill_wait_iaddr", iaddr, addr);
      check_eq("fill_wait_ihit", 32'(ihit), 32'd0);
      tick();
    end
    iwait = 1'b0; iload = data;
    #1;
    check_eq("fill_done_iren", 32'(iREN), 32'd1);
    check_eq("fill_done_iaddr", iaddr, addr);
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    check_eq("fill_hit_ihit", 32'(ihit), 32'd1);
    check_eq("fill_hit_data", imemload, data);
    check_eq("fill_hit_iren", 32'(iREN), 32'd0);
    check_eq("fill_hit_iaddr", iaddr, 32'h0);
    tick(); exp_hit++;
    imemREN = 1'b0;
  endtask

  // Single-cycle look-up that is withdrawn before the edge (no counter effect).
  task automatic probe(input string tag, input logic [31:0] addr, input logic hit, input logic [31:0] data);
    imemREN = 1'b1; imemaddr = addr;
    #1;
    check_eq({tag, "_ihit"}, 32'(ihit), 32'(hit));
    check_eq({tag, "_data"}, imemload, hit ? data : 32'h0);
    imemREN = 1'b0;
    tick();
  endtask

  initial begin
    nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; flush = 1'b0;
    iwait = 1'b1; iload = 32'h0;
    #1;
    check_eq("rst_iren", 32'(iREN), 32'd0);
    check_eq("rst_ihit", 32'(ihit), 32'd0);
    check_counts("rst");
    tick(); tick();
    nRST = 1'b1;
    tick();

    // Cold miss with three wait cycles.
    fill(32'h0000_0040, 32'h8C22_0004, 3);
    check_counts("cold");

    // Conflict on index 0: 0x0 evicts 0x40, 0x40 evicts 0x0.
    fill(32'h0000_0000, 32'h1111_1111, 1);
    probe("conf_40_gone", 32'h0000_0040, 1'b0, 32'h0);
    fill(32'h0000_0040, 32'h2222_2222, 0);
    probe("conf_0_gone", 32'h0000_0000, 1'b0, 32'h0);
    check_counts("conf");

    // Ten back-to-back hits.
    imemREN = 1'b1; imemaddr = 32'h0000_0040;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("rep_ihit", 32'(ihit), 32'd1);
      check_eq("rep_data", imemload, 32'h2222_2222);
      check_eq("rep_iren", 32'(iREN), 32'd0);
      tick(); exp_hit++;
    end
    imemREN = 1'b0;
    check_counts("rep");

    // Flush in IDLE invalidates a cached line and masks the same-cycle hit.
    fill(32'h0000_0100, 32'h3333_3333, 0);
    probe("fl_pre", 32'h0000_0100, 1'b1, 32'h3333_3333);
    imemREN = 1'b1; imemaddr = 32'h0000_0100; flush = 1'b1;
    #1;
    check_eq("fl_force_ihit", 32'(ihit), 32'd0);
    tick();
    flush = 1'b0; imemREN = 1'b0;
    probe("fl_post", 32'h0000_0100, 1'b0, 32'h0);
    check_counts("fl");

    // Flush coinciding with iwait=0 abandons the fill.
    imemREN = 1'b1; imemaddr = 32'h0000_0100; iwait = 1'b1;
    tick(); exp_miss++;
    #1;
    check_eq("flf_iren", 32'(iREN), 32'd1);
    iwait = 1'b0; iload = 32'h4444_4444; flush = 1'b1;
    tick();
    flush = 1'b0; iwait = 1'b1; iload = 32'h0;
    #1;
    check_eq("flf_idle_iren", 32'(iREN), 32'd0);
    check_eq("flf_not_written", 32'(ihit), 32'd0);
    imemREN = 1'b0;
    tick();
    check_counts("flf");

    // Address moves during FILL: the latched address is the one filled.
    imemREN = 1'b1; imemaddr = 32'h0000_0200; iwait = 1'b1;
    tick(); exp_miss++;
    imemaddr = 32'h0000_0204;
    #1;
    check_eq("mid_iaddr_wait", iaddr, 32'h0000_0200);
    iwait = 1'b0; iload = 32'h5555_5555;
    #1;
    check_eq("mid_iaddr_done", iaddr, 32'h0000_0200);
    tick();
    iwait = 1'b1; iload = 32'h0;
    #1;
    check_eq("mid_204_ihit", 32'(ihit), 32'd0);
    imemaddr = 32'h0000_0200;
    #1;
    check_eq("mid_200_ihit", 32'(ihit), 32'd1);
    check_eq("mid_200_data", imemload, 32'h5555_5555);
    imemREN = 1'b0;
    tick();
    probe("mid_204_miss", 32'h0000_0204, 1'b0, 32'h0);
    check_counts("mid");

    // Asynchronous reset during FILL.
    imemREN = 1'b1; imemaddr = 32'h0000_0308; iwait = 1'b1;
    tick(); exp_miss++;
    #1;
    check_eq("arst_pre_iren", 32'(iREN), 32'd1);
    #1;
    nRST = 1'b0;
    #1;
    check_eq("arst_iren", 32'(iREN), 32'd0);
    check_eq("arst_iaddr", iaddr, 32'h0);
    exp_hit = 0; exp_miss = 0;
    check_counts("arst");
    imemREN = 1'b0;
    tick();
    nRST = 1'b1;
    tick();
    probe("arst_200_miss", 32'h0000_0200, 1'b0, 32'h0);
    fill(32'h0000_0308, 32'h6666_6666, 2);
    check_counts("arst_after");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
